gmii_tx_framer: RTL

// - Transmit end of the Ethernet MAC link: consumes a 32-bit word stream (payload = dst MAC .. end of L3 data)
//   and drives the GMII TX pins with preamble, SFD, optional min-size padding, FCS and inter-frame gap.
// - Runs in the MAC TX clock domain, downstream of the transmit elastic buffer; one byte per clock on GMII.

---
 rtl/gmii_tx_framer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/gmii_tx_framer.sv
`default_nettype none
//============================================================================
// Module   : gmii_tx_framer
// Purpose  : Ethernet MAC transmit framer. Takes a 32-bit big-endian word
//            stream (dst MAC .. end of L3 data) and drives GMII TX with
//            preamble, SFD, optional zero padding, CRC-32 FCS and the
//            inter-frame gap. One byte per clock on the GMII side.
// Options  : GMII_TX_PAD_EN - when defined, frames shorter than
//            MIN_FRAME_LEN are zero-padded before the FCS. When undefined,
//            short frames go out as supplied (runt-frame test mode).
// Revision : 1.0 - initial release
//============================================================================
module gmii_tx_framer #(
    parameter int IFG_BYTES     = 12,
    parameter int MIN_FRAME_LEN = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes_valid,
    input  logic        in_last,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_txd,
    output logic [31:0] perf_frames_sent,
    output logic [15:0] perf_underruns
);

    // State encoding: r_state always names what is on the GMII pins this cycle.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;
    localparam logic [2:0] S_IFG  = 3'd7;

    localparam logic [31:0] c_crc_poly = 32'hEDB88320;
    localparam logic [10:0] c_min_len  = 11'(MIN_FRAME_LEN);
    localparam logic [7:0]  c_ifg_last = 8'(IFG_BYTES - 1);
`ifdef GMII_TX_PAD_EN
    localparam logic        c_pad_en   = 1'b1;
`else
    localparam logic        c_pad_en   = 1'b0;
`endif

    logic [2:0]  r_state, w_state_nxt;
    logic [2:0]  r_pre_cnt;
    logic [1:0]  r_fcs_idx;
    logic [7:0]  r_ifg_cnt;
    logic [31:0] r_word;
    logic [2:0]  r_bv;
    logic        r_last;
    logic [1:0]  r_idx;
    logic [10:0] r_cnt;
    logic [31:0] r_crc;
    logic [7:0]  r_txd;
    logic        r_tx_en, r_tx_er;
    logic [31:0] r_frames;
    logic [15:0] r_underruns;

    logic [7:0]  w_txd, w_byte, w_next_data, w_fcs_next;
    logic        w_tx_en, w_tx_er, w_load, w_push, w_frame_done, w_underrun;
    logic        w_word_end, w_pad_needed;
    logic [31:0] w_fcs;

    // Byte-wise reflected CRC-32 update, LSB of each byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
        end
        return c;
    endfunction

    assign w_word_end   = ({1'b0, r_idx} == (r_bv - 3'd1));
    assign w_pad_needed = c_pad_en && (r_cnt < c_min_len);
    assign w_fcs        = ~r_crc;
    assign in_ready     = (r_state == S_SFD) || ((r_state == S_DATA) && w_word_end && !r_last);

    // Byte following the one currently on the wire, for the latched word and the FCS.
    always_comb begin
        w_next_data = r_word[31:24];
        w_fcs_next  = w_fcs[7:0];
        case (r_idx)
            2'd0:    w_next_data = r_word[23:16];
            2'd1:    w_next_data = r_word[15:8];
            2'd2:    w_next_data = r_word[7:0];
            default: w_next_data = r_word[31:24];
        endcase
        case (r_fcs_idx)
            2'd0:    w_fcs_next = w_fcs[15:8];
            2'd1:    w_fcs_next = w_fcs[23:16];
            2'd2:    w_fcs_next = w_fcs[31:24];
            default: w_fcs_next = w_fcs[7:0];
        endcase
    end

    // Next state plus the GMII values that will be registered alongside it.
    always_comb begin
        w_state_nxt  = r_state;
        w_txd        = 8'h00;
        w_tx_en      = 1'b0;
        w_tx_er      = 1'b0;
        w_load       = 1'b0;
        w_push       = 1'b0;
        w_byte       = 8'h00;
        w_frame_done = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_PRE;
                    w_tx_en     = 1'b1;
                    w_txd       = 8'h55;
                end
            end
            S_PRE: begin
                w_tx_en = 1'b1;
                if (r_pre_cnt == 3'd6) begin
                    w_state_nxt = S_SFD;
                    w_txd       = 8'hD5;
                end else begin
                    w_txd       = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                if ((r_state == S_DATA) && !w_word_end) begin
                    w_push  = 1'b1;
                    w_byte  = w_next_data;
                    w_tx_en = 1'b1;
                    w_txd   = w_next_data;
                end else if (in_ready && in_valid) begin
                    w_state_nxt = S_DATA;
                    w_load      = 1'b1;
                    w_push      = 1'b1;
                    w_byte      = in_data[31:24];
                    w_tx_en     = 1'b1;
                    w_txd       = in_data[31:24];
                end else if (in_ready) begin
                    // Upstream starved us mid-frame: flag the error and abandon.
                    w_state_nxt = S_ERR;
                    w_tx_en     = 1'b1;
                    w_tx_er     = 1'b1;
                    w_underrun  = 1'b1;
                end else if (w_pad_needed) begin
                    w_state_nxt = S_PAD;
                    w_push      = 1'b1;
                    w_tx_en     = 1'b1;
                end else begin
                    w_state_nxt = S_FCS;
                    w_tx_en     = 1'b1;
                    w_txd       = w_fcs[7:0];
                end
            end
            S_PAD: begin
                w_tx_en = 1'b1;
                if (w_pad_needed) begin
                    w_push      = 1'b1;
                end else begin
                    w_state_nxt = S_FCS;
                    w_txd       = w_fcs[7:0];
                end
            end
            S_FCS: begin
                if (r_fcs_idx == 2'd3) begin
                    w_state_nxt  = S_IFG;
                    w_frame_done = 1'b1;
                end else begin
                    w_tx_en = 1'b1;
                    w_txd   = w_fcs_next;
                end
            end
            S_ERR: begin
                w_state_nxt = S_IFG;
            end
            S_IFG: begin
                if (r_ifg_cnt == c_ifg_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, registered GMII outputs and per-state cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_txd     <= 8'h00;
            r_tx_en   <= 1'b0;
            r_tx_er   <= 1'b0;
            r_pre_cnt <= 3'd0;
            r_fcs_idx <= 2'd0;
            r_ifg_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_txd     <= w_txd;
            r_tx_en   <= w_tx_en;
            r_tx_er   <= w_tx_er;
            r_pre_cnt <= (r_state == S_PRE) ? r_pre_cnt + 3'd1 : 3'd0;
            r_fcs_idx <= (r_state == S_FCS) ? r_fcs_idx + 2'd1 : 2'd0;
            r_ifg_cnt <= (r_state == S_IFG) ? r_ifg_cnt + 8'd1 : 8'd0;
        end
    end

    // Word latch, byte pointer, saturating frame length and running CRC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= 32'd0;
            r_bv   <= 3'd0;
            r_last <= 1'b0;
            r_idx  <= 2'd0;
            r_cnt  <= 11'd0;
            r_crc  <= 32'hFFFFFFFF;
        end else begin
            if (w_load) begin
                r_word <= in_data;
                r_bv   <= in_bytes_valid;
                r_last <= in_last;
                r_idx  <= 2'd0;
            end else if (w_push) begin
                r_idx  <= r_idx + 2'd1;
            end
            if (r_state == S_IDLE) begin
                r_cnt <= 11'd0;
                r_crc <= 32'hFFFFFFFF;
            end else if (w_push) begin
                r_cnt <= (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
                r_crc <= crc32_byte(r_crc, w_byte);
            end
        end
    end

    // Performance counters: good frames wrap, underruns saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames    <= 32'd0;
            r_underruns <= 16'd0;
        end else begin
            if (w_frame_done) begin
                r_frames <= r_frames + 32'd1;
            end
            if (w_underrun && (r_underruns != 16'hFFFF)) begin
                r_underruns <= r_underruns + 16'd1;
            end
        end
    end

    assign gmii_txd         = r_txd;
    assign gmii_tx_en       = r_tx_en;
    assign gmii_tx_er       = r_tx_er;
    assign perf_frames_sent = r_frames;
    assign perf_underruns   = r_underruns;

endmodule
`default_nettype wire
